// File: rtl/ct_lsu_dcache_pkg.sv
// Shared definitions for the LSU dcache data bank.
// Holds the default geometry, the starvation limit, and small per-byte helper
// functions for parity and write-enable mask expansion.
package ct_lsu_dcache_pkg;

  localparam int DEF_WIDTH        = 32;
  localparam int DEF_DEPTH        = 2048;
  localparam int DEF_STARVE_LIMIT = 4;

  // Even parity bit for one byte: the stored bit makes the 9-bit XOR equal to zero.
  function automatic logic byte_par(input logic [7:0] b);
    return ^b;
  endfunction

  // Expands one byte-enable bit into an 8-bit per-bit mask.
  function automatic logic [7:0] be_to_mask(input logic be);
    return {8{be}};
  endfunction

endpackage

// File: rtl/ct_spsram_param.sv
// Behavioural single-port SRAM.
// CEN and GWEN are active-low. WEN is a per-bit active-low write mask.
// Q is registered, so read data appears the cycle after an enabled read.
// The contents are not reset.
module ct_spsram_param #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2048,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             CLK,
  input  logic             CEN,
  input  logic             GWEN,
  input  logic [WIDTH-1:0] WEN,
  input  logic [AW-1:0]    A,
  input  logic [WIDTH-1:0] D,
  output logic [WIDTH-1:0] Q
);

  logic [WIDTH-1:0] mem [0:DEPTH-1];
  logic [WIDTH-1:0] q_q;

  // Masked write, or registered read, on an enabled cycle.
  always_ff @(posedge CLK) begin
    if (!CEN) begin
      if (!GWEN) mem[A] <= (mem[A] & WEN) | (D & ~WEN);
      else       q_q    <= mem[A];
    end
  end

  assign Q = q_q;

endmodule

// File: rtl/gated_clk_cell.sv
// Latch-based integrated clock gate.
// The enable is captured while clk_in is low, so clk_out never glitches.
// Scan enable forces the clock through.
module gated_clk_cell (
  input  logic clk_in,
  input  logic global_en,
  input  logic module_en,
  input  logic local_en,
  input  logic external_en,
  input  logic pad_yy_icg_scan_en,
  output logic clk_out
);

  logic clk_en_bf_latch;
  logic clk_en_latch;

  assign clk_en_bf_latch = (global_en & (module_en | local_en)) | external_en;

  // Transparent-low enable latch.
  always_latch begin
    if (!clk_in) clk_en_latch <= clk_en_bf_latch;
  end

  assign clk_out = clk_in & (clk_en_latch | pad_yy_icg_scan_en);

endmodule

// File: rtl/ct_lsu_dcache_data_bank.sv
// Dcache data bank controller.
// It wraps a single-port SRAM behind a valid/ready request port. The bank
// adds a one-entry write buffer, same-index write coalescing, read-after-write
// byte bypass and a starvation-forced drain.
// Optional feature macro: DCACHE_DATA_PARITY_EN adds one even-parity bit per
// byte to the SRAM word and reports mismatches on rd_perr.
//
// Handshake: a request is accepted on a rising clock edge where
// req_vld && req_rdy. req_rdy depends only on internal state, never on
// req_vld. A requester that sees req_rdy low must hold the request unchanged.
module ct_lsu_dcache_data_bank
  import ct_lsu_dcache_pkg::*;
#(
  parameter int WIDTH        = DEF_WIDTH,
  parameter int DEPTH        = DEF_DEPTH,
  parameter int STARVE_LIMIT = DEF_STARVE_LIMIT,
  localparam int BE          = WIDTH / 8,
  localparam int AW          = $clog2(DEPTH)
) (
  input  logic             forever_cpuclk,
  input  logic             cpurst,
  input  logic             pad_yy_icg_scan_en,
  input  logic             cp0_lsu_icg_en,
  input  logic             req_vld,
  output logic             req_rdy,
  input  logic             req_wr,
  input  logic [AW-1:0]    req_idx,
  input  logic [BE-1:0]    req_be,
  input  logic [WIDTH-1:0] req_din,
  output logic             rd_vld,
  output logic [WIDTH-1:0] rd_dout,
  output logic             rd_perr,
  output logic             wbuf_vld
);

`ifdef DCACHE_DATA_PARITY_EN
  localparam int SW = WIDTH + BE;
`else
  localparam int SW = WIDTH;
`endif

  localparam logic [3:0] STARVE_LIM = 4'(STARVE_LIMIT);

  // Write buffer
  logic             wbuf_vld_q, wbuf_vld_d;
  logic [AW-1:0]    wbuf_idx_q, wbuf_idx_d;
  logic [BE-1:0]    wbuf_be_q, wbuf_be_d;
  logic [WIDTH-1:0] wbuf_data_q, wbuf_data_d;

  // Starvation counter and read pipeline / bypass snapshot
  logic [3:0]       starve_cnt_q, starve_cnt_d;
  logic             rd_vld_q, rd_vld_d;
  logic [BE-1:0]    snap_be_q, snap_be_d;
  logic [WIDTH-1:0] snap_data_q, snap_data_d;

  // Request decode
  logic force_drain;
  logic rd_acc;
  logic wr_acc;
  logic idx_hit;
  logic coalesce;
  logic drain;

  // SRAM interface
  logic             sram_clk;
  logic             sram_cen;
  logic             sram_gwen;
  logic [SW-1:0]    sram_wen;
  logic [AW-1:0]    sram_a;
  logic [SW-1:0]    sram_d;
  logic [SW-1:0]    sram_q;
  logic [WIDTH-1:0] rd_merged;

  assign force_drain = wbuf_vld_q && (starve_cnt_q == STARVE_LIM);
  assign req_rdy     = !force_drain;
  assign rd_acc      = req_vld && req_rdy && !req_wr;
  assign wr_acc      = req_vld && req_rdy && req_wr;
  assign idx_hit     = wbuf_vld_q && (req_idx == wbuf_idx_q);
  assign coalesce    = wr_acc && idx_hit;
  // The SRAM port is free whenever no read uses it; a coalesce keeps the entry.
  assign drain       = wbuf_vld_q && !rd_acc && !coalesce;

  // Write buffer: capture, coalesce into the held entry, or empty after a drain.
  always_comb begin
    wbuf_vld_d  = wbuf_vld_q;
    wbuf_idx_d  = wbuf_idx_q;
    wbuf_be_d   = wbuf_be_q;
    wbuf_data_d = wbuf_data_q;
    if (coalesce) begin
      wbuf_be_d = wbuf_be_q | req_be;
      for (int b = 0; b < BE; b++) begin
        if (req_be[b]) wbuf_data_d[b*8 +: 8] = req_din[b*8 +: 8];
      end
    end else if (wr_acc) begin
      wbuf_vld_d  = 1'b1;
      wbuf_idx_d  = req_idx;
      wbuf_be_d   = req_be;
      wbuf_data_d = req_din;
    end else if (drain) begin
      wbuf_vld_d = 1'b0;
    end
  end

  // Starvation count: reads accepted while the buffer waits, cleared by any drain.
  always_comb begin
    starve_cnt_d = starve_cnt_q;
    if (!wbuf_vld_q || drain) starve_cnt_d = '0;
    else if (rd_acc)          starve_cnt_d = starve_cnt_q + 4'd1;
  end

  // Read pipeline: snapshot the buffered bytes that the accepted read must see.
  always_comb begin
    rd_vld_d    = rd_acc;
    snap_be_d   = snap_be_q;
    snap_data_d = snap_data_q;
    if (rd_acc) begin
      snap_be_d   = idx_hit ? wbuf_be_q : '0;
      snap_data_d = wbuf_data_q;
    end
  end

  // State registers.
  always_ff @(posedge forever_cpuclk or posedge cpurst) begin
    if (cpurst) begin
      wbuf_vld_q   <= 1'b0;
      wbuf_idx_q   <= '0;
      wbuf_be_q    <= '0;
      wbuf_data_q  <= '0;
      starve_cnt_q <= '0;
      rd_vld_q     <= 1'b0;
      snap_be_q    <= '0;
      snap_data_q  <= '0;
    end else begin
      wbuf_vld_q   <= wbuf_vld_d;
      wbuf_idx_q   <= wbuf_idx_d;
      wbuf_be_q    <= wbuf_be_d;
      wbuf_data_q  <= wbuf_data_d;
      starve_cnt_q <= starve_cnt_d;
      rd_vld_q     <= rd_vld_d;
      snap_be_q    <= snap_be_d;
      snap_data_q  <= snap_data_d;
    end
  end

  // SRAM write data and active-low per-bit mask built from the buffer entry.
  always_comb begin
    sram_wen = '1;
    sram_d   = '0;
    for (int b = 0; b < BE; b++) begin
      sram_wen[b*8 +: 8] = ~be_to_mask(wbuf_be_q[b]);
      sram_d[b*8 +: 8]   = wbuf_data_q[b*8 +: 8];
`ifdef DCACHE_DATA_PARITY_EN
      sram_wen[WIDTH+b]  = ~wbuf_be_q[b];
      sram_d[WIDTH+b]    = byte_par(wbuf_data_q[b*8 +: 8]);
`endif
    end
  end

  assign sram_cen  = !(rd_acc || drain);
  assign sram_gwen = !drain;
  assign sram_a    = drain ? wbuf_idx_q : req_idx;

  gated_clk_cell u_icg (
    .clk_in             (forever_cpuclk),
    .global_en          (1'b1),
    .module_en          (cp0_lsu_icg_en),
    .local_en           (rd_acc || drain),
    .external_en        (1'b0),
    .pad_yy_icg_scan_en (pad_yy_icg_scan_en),
    .clk_out            (sram_clk)
  );

  ct_spsram_param #(
    .WIDTH (SW),
    .DEPTH (DEPTH)
  ) u_sram (
    .CLK  (sram_clk),
    .CEN  (sram_cen),
    .GWEN (sram_gwen),
    .WEN  (sram_wen),
    .A    (sram_a),
    .D    (sram_d),
    .Q    (sram_q)
  );

  // Read data: buffered bytes from the snapshot override SRAM bytes.
  always_comb begin
    rd_merged = '0;
    for (int b = 0; b < BE; b++) begin
      rd_merged[b*8 +: 8] = snap_be_q[b] ? snap_data_q[b*8 +: 8] : sram_q[b*8 +: 8];
    end
  end

  assign rd_dout  = rd_vld_q ? rd_merged : '0;
  assign rd_vld   = rd_vld_q;
  assign wbuf_vld = wbuf_vld_q;

`ifdef DCACHE_DATA_PARITY_EN
  logic [BE-1:0] perr_vec;

  // Parity mismatch per byte, ignoring bytes supplied by bypass.
  always_comb begin
    perr_vec = '0;
    for (int b = 0; b < BE; b++) begin
      perr_vec[b] = !snap_be_q[b] && (byte_par(sram_q[b*8 +: 8]) != sram_q[WIDTH+b]);
    end
  end

  assign rd_perr = rd_vld_q && (|perr_vec);
`else
  assign rd_perr = 1'b0;
`endif

endmodule

// File: doc/ct_lsu_dcache_data_bank.md
# ct_lsu_dcache_data_bank

Parametrised dcache data bank controller for the LSU. It wraps one single-port data SRAM behind a valid/ready request port and adds a one-entry write buffer, same-index write coalescing and read-after-write byte bypass. A starvation counter forces the buffer to drain, and optional per-byte parity can be compiled in. It sits between the LSU data-path request muxing and the SRAM macro, and replaces the fixed 32-bit, no-buffer array wrapper.

## Interface
- WIDTH, 32: data word width in bits; must be a multiple of 8; BE = WIDTH/8.
- DEPTH, 2048: number of words; AW = clog2(DEPTH).
- STARVE_LIMIT, 4: consecutive read-accepted cycles with the buffer full before a forced drain; range 1..15.

Ports:
- forever_cpuclk  in  1  free-running core clock.
- cpurst  in  1  asynchronous reset, active-high.
- pad_yy_icg_scan_en  in  1  scan enable for the ICG.
- cp0_lsu_icg_en  in  1  module-level clock-gate enable.
- req_vld  in  1  request valid.
- req_rdy  out  1  request accepted when req_vld && req_rdy.
- req_wr  in  1  1 = write, 0 = read.
- req_idx  in  AW  word index.
- req_be  in  BE  byte enables; write only, ignored on reads.
- req_din  in  WIDTH  write data.
- rd_vld  out  1  read data valid, one cycle pulse.
- rd_dout  out  WIDTH  read data.
- rd_perr  out  1  parity error on this read.
- wbuf_vld  out  1  write buffer holds pending data.

## Operation
**Request types**
- A read that is accepted issues the SRAM read in the same cycle.
- A write that is accepted never touches the SRAM directly. It is captured into the write buffer (wbuf: idx, be, data).

**Writing the buffer**
- wbuf empty: capture the write.
- wbuf full, same idx: coalesce. Bytes with be set overwrite the buffer, and the buffer's be becomes the OR of old and new.
- wbuf full, different idx: drain the old entry to the SRAM in this cycle (the port is free) and capture the new one.

**Draining**
- wbuf drains to the SRAM in any cycle with no accepted read and no same-idx coalesce.
- The SRAM write uses WEN = ~be expanded per bit.
- wbuf_vld clears after the drain unless a new write is captured in the same cycle.

**Starvation**
- starve_cnt increments on each cycle where a read is accepted while wbuf_vld.
- It clears on drain or when wbuf is empty.
- When starve_cnt == STARVE_LIMIT, req_rdy = 0 for exactly one cycle. The buffer drains in that cycle and the count clears.
- req_rdy is 1 in every other case.

**Read bypass**
- The wbuf contents are snapshotted at read acceptance.
- If the read idx equals the wbuf idx, rd_dout takes buffered bytes for the snapshot's be bits and SRAM Q for the remaining bytes.

**Clock gating**
- The SRAM clock is gated by gated_clk_cell with local_en = (read accepted) | drain.
- module_en = cp0_lsu_icg_en, external_en = 0, global_en = 1.

## Timing
- Read accepted at cycle T: rd_vld = 1 at T+1, with rd_dout and rd_perr valid at T+1.
  - rd_dout is combinational from SRAM Q plus the registered bypass snapshot.
- Write accepted at T: wbuf_vld = 1 from T+1.
  - The earliest SRAM write is at T+1.
  - A read of the same idx at T+1 returns the written bytes through bypass.
- A drain at T is visible to a non-bypassed SRAM read at T+1 or later.
- Simultaneous events:
  - A read request in the forced-drain cycle is not accepted and must be held by the requester.
  - A write request in that cycle is also not accepted.
- Reset, asynchronous:
  - Outputs: wbuf_vld = 0, rd_vld = 0, rd_perr = 0, rd_dout = 0, req_rdy = 1.
  - State: starve_cnt = 0, bypass snapshot cleared.
  - Buffered write data is discarded. A read in flight when reset asserts produces no rd_vld.
  - SRAM contents are not reset.

## Configuration
- DCACHE_DATA_PARITY_EN defined:
  - The SRAM is WIDTH+BE bits wide and stores one even-parity bit per byte, computed at drain time.
  - On read, rd_perr = OR of parity mismatches over bytes not supplied by bypass. Bypassed bytes never flag an error.
  - rd_perr is valid with rd_vld only and is 0 otherwise.
- DCACHE_DATA_PARITY_EN undefined:
  - The SRAM is WIDTH bits wide with no parity logic.
  - rd_perr is tied to 0.

## Structure
- Package ct_lsu_dcache_pkg holds:
  - the byte-parity function;
  - the be-to-bit-mask expansion function;
  - the default WIDTH, DEPTH and STARVE_LIMIT constants.
- Sub-module ct_spsram_param is the behavioural single-port SRAM.
  - Parameters: WIDTH, DEPTH.
  - Active-low CEN and GWEN, per-bit active-low WEN.
  - Q is registered, so read data appears the cycle after CEN.
- gated_clk_cell is reused unchanged.

## Test plan
- Write idx 5, be=0xF, data 0xA5A5A5A5 at T; idle; read idx 5 at T+3 -> rd_vld at T+4, rd_dout = 0xA5A5A5A5, rd_perr = 0.
- SRAM idx 9 = 0x11223344; write idx 9, be=0x1, 0xFF at T; read idx 9 at T+1 -> rd_dout at T+2 = 0x112233FF through bypass.
- Write idx 3 be=0x1 0x000000AA, then write idx 3 be=0x4 0x00BB0000 back-to-back -> single drain, later read = old bytes with 0xBB and 0xAA merged, wbuf_vld low after drain.
- Write idx 7, then continuous reads to idx 0 with STARVE_LIMIT = 4 -> req_rdy low exactly one cycle after the 4th read, drain occurs, a read of idx 7 then returns the SRAM value.
- Write accepted, cpurst pulsed at T+1 before the drain -> wbuf_vld = 0, and a subsequent read of that idx returns the pre-write SRAM value.
- With DCACHE_DATA_PARITY_EN: write 0x12345678, flip byte-1 parity bit via backdoor, read -> rd_perr = 1. Repeat with a bypassed byte 1 -> rd_perr = 0.
